// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, requester indices, helpers.
// Selection policy is chosen by MEM_ARBITER_ROUND_ROBIN_EN (defined: round robin, else fixed priority).
package mem_arbiter_pkg;

  localparam int NUM_REQ   = 3;
  localparam int MODE_W    = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DEBUG = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Wraps requester indices modulo NUM_REQ.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational winner selection among the three requesters.
// MEM_ARBITER_ROUND_ROBIN_EN selects round robin from a pointer; otherwise fixed priority 1 > 0 > 2.
module mem_arbiter_picker
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  logic [1:0]         ptr_i,
`endif
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  assign valid_o = |req_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [1:0] cand1, cand2;

  assign cand1 = next_idx(ptr_i);
  assign cand2 = next_idx(cand1);

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    winner_o = '0;
    if (req_i[ptr_i])      winner_o[ptr_i] = 1'b1;
    else if (req_i[cand1]) winner_o[cand1] = 1'b1;
    else if (req_i[cand2]) winner_o[cand2] = 1'b1;
  end
`else
  always_comb begin
    winner_o = '0;
    if (req_i[REQ_DATA])       winner_o[REQ_DATA]  = 1'b1;
    else if (req_i[REQ_FETCH]) winner_o[REQ_FETCH] = 1'b1;
    else if (req_i[REQ_DEBUG]) winner_o[REQ_DEBUG] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Sequences fetch, load/store and debug requesters onto the single memory_control port.
// MEM_ARBITER_ROUND_ROBIN_EN enables round-robin selection; default is fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*MODE_W-1:0] req_mode,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_start,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [MODE_W-1:0]         mem_mode,
  output logic                      mem_write_enable,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic                      mem_active,
  input  logic                      mem_done,
  input  logic [DATA_W-1:0]         mem_read_data
);

  // A zero timeout still needs a one-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q;
  logic [1:0]          idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  gnt_q, done_q, err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_start_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MODE_W-1:0]   mode_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NUM_REQ-1:0]  win;
  logic                win_valid;
  logic [1:0]          win_idx_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
`endif

  mem_arbiter_picker u_picker (
    .req_i    (req),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    .ptr_i    (ptr_q),
`endif
    .winner_o (win),
    .valid_o  (win_valid)
  );

  assign win_idx_d = onehot_to_idx(win);

  // NOTE: every register here uses <= so all of them sample pre-edge values consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      mem_start_q <= 1'b0;
      addr_q      <= '0;
      mode_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      mem_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid && !mem_active) begin
            idx_q       <= win_idx_d;
            addr_q      <= req_addr[int'(win_idx_d)*ADDR_W +: ADDR_W];
            mode_q      <= req_mode[int'(win_idx_d)*MODE_W +: MODE_W];
            we_q        <= req_we[win_idx_d];
            wdata_q     <= req_wdata[int'(win_idx_d)*DATA_W +: DATA_W];
            gnt_q       <= win;
            mem_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            ptr_q       <= next_idx(win_idx_d);
`endif
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_done) begin
            rdata_q <= mem_read_data;
            done_q  <= idx_to_onehot(idx_q);
            state_q <= ST_RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_VAL) begin
            rdata_q <= '0;
            done_q  <= idx_to_onehot(idx_q);
            err_q   <= idx_to_onehot(idx_q);
            state_q <= ST_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign err              = err_q;
  assign rdata            = rdata_q;
  assign mem_start        = mem_start_q;
  assign mem_address      = addr_q;
  assign mem_mode         = mode_q;
  assign mem_write_enable = we_q;
  assign mem_write_data   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter, built with TIMEOUT_CYCLES=8.
// Expected grant order follows MEM_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO     = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [8:0]          req_mode;
  logic [2:0]          req_we;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          gnt, done, err;
  logic [DATA_W-1:0]   rdata;
  logic                mem_start;
  logic [ADDR_W-1:0]   mem_address;
  logic [2:0]          mem_mode;
  logic                mem_write_enable;
  logic [DATA_W-1:0]   mem_write_data;
  logic                mem_active;
  logic                mem_done;
  logic [DATA_W-1:0]   mem_read_data;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_addr         (req_addr),
    .req_mode         (req_mode),
    .req_we           (req_we),
    .req_wdata        (req_wdata),
    .gnt              (gnt),
    .done             (done),
    .err              (err),
    .rdata            (rdata),
    .mem_start        (mem_start),
    .mem_address      (mem_address),
    .mem_mode         (mem_mode),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_active       (mem_active),
    .mem_done         (mem_done),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [2:0] mode,
                         input logic we, input logic [31:0] wdata);
    req_addr[i*ADDR_W +: ADDR_W]  = addr;
    req_mode[i*3 +: 3]            = mode;
    req_we[i]                     = we;
    req_wdata[i*DATA_W +: DATA_W] = wdata;
  endtask

  logic [2:0] exp_order [5];

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_mode = '0; req_we = '0; req_wdata = '0;
    mem_active = 1'b0; mem_done = 1'b0; mem_read_data = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`else
    exp_order = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
`endif

    // Reset state
    tick(); tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_mem_start", mem_start, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_address, 0);
    rst = 1'b0;

    // Fetch alone, mem_done three cycles after mem_start
    set_req(0, 32'h100, 3'b010, 1'b0, 32'h0);
    req[0] = 1'b1;
    check("fetch_pre_gnt", gnt, 0);
    tick();
    check("fetch_gnt", gnt, 3'b001);
    check("fetch_start", mem_start, 1);
    check("fetch_addr", mem_address, 32'h100);
    check("fetch_mode", mem_mode, 3'b010);
    check("fetch_we", mem_write_enable, 0);
    req[0] = 1'b0;
    tick();
    check("fetch_start_pulse", mem_start, 0);
    check("fetch_gnt_pulse", gnt, 0);
    tick();
    tick();
    mem_done = 1'b1; mem_read_data = 32'hDEADBEEF;
    check("fetch_no_early_done", done, 0);
    tick();
    check("fetch_done", done, 3'b001);
    check("fetch_rdata", rdata, 32'hDEADBEEF);
    check("fetch_err", err, 0);
    mem_done = 1'b0; mem_read_data = 32'h5555_5555;
    tick();
    check("fetch_done_pulse", done, 0);
    check("fetch_rdata_hold", rdata, 32'hDEADBEEF);

    // Load/store beats fetch when both rise together
    set_req(0, 32'h104, 3'b010, 1'b0, 32'h0);
    set_req(1, 32'h1000, 3'b010, 1'b0, 32'h0);
    req = 3'b011;
    tick();
    check("prio_gnt1", gnt, 3'b010);
    check("prio_addr1", mem_address, 32'h1000);
    req[1] = 1'b0;
    tick();
    mem_done = 1'b1; mem_read_data = 32'h11;
    tick();
    check("prio_done1", done, 3'b010);
    mem_done = 1'b0;
    tick();
    check("prio_idle_no_gnt", gnt, 0);
    tick();
    check("prio_gnt0", gnt, 3'b001);
    check("prio_addr0", mem_address, 32'h104);
    req[0] = 1'b0;
    tick();
    mem_done = 1'b1; mem_read_data = 32'h22;
    tick();
    check("prio_done0", done, 3'b001);
    check("prio_rdata0", rdata, 32'h22);
    mem_done = 1'b0;
    tick();

    // Store: write command latched and held
    set_req(1, 32'h2000, 3'b010, 1'b1, 32'h12345678);
    req[1] = 1'b1;
    tick();
    check("store_gnt", gnt, 3'b010);
    check("store_start", mem_start, 1);
    check("store_we", mem_write_enable, 1);
    check("store_wdata", mem_write_data, 32'h12345678);
    check("store_addr", mem_address, 32'h2000);
    req[1] = 1'b0;
    set_req(1, 32'h0, 3'b000, 1'b0, 32'h0);
    tick();
    mem_done = 1'b1; mem_read_data = 32'hAAAA_AAAA;
    tick();
    check("store_done", done, 3'b010);
    check("store_err", err, 0);
    check("store_we_held", mem_write_enable, 1);
    mem_done = 1'b0;
    tick();
    check("store_addr_kept_idle", mem_address, 32'h2000);
    check("store_wdata_kept_idle", mem_write_data, 32'h12345678);

    // Debug request that times out after TO wait cycles
    set_req(2, 32'h300, 3'b000, 1'b0, 32'h0);
    req[2] = 1'b1;
    tick();
    check("to_gnt", gnt, 3'b100);
    check("to_start", mem_start, 1);
    req[2] = 1'b0;
    repeat (9) tick();
    check("to_not_yet", done, 0);
    tick();
    check("to_done", done, 3'b100);
    check("to_err", err, 3'b100);
    check("to_rdata", rdata, 0);
    tick();
    check("to_done_pulse", done, 0);
    check("to_err_pulse", err, 0);

    // Busy memory blocks arbitration; a withdrawn request is never granted
    mem_active = 1'b1;
    set_req(0, 32'h500, 3'b001, 1'b0, 32'h0);
    set_req(2, 32'h600, 3'b001, 1'b0, 32'h0);
    req = 3'b101;
    tick();
    check("busy_no_gnt", gnt, 0);
    check("busy_no_start", mem_start, 0);
    req[2] = 1'b0;
    mem_active = 1'b0;
    tick();
    check("busy_release_gnt", gnt, 3'b001);
    check("busy_release_addr", mem_address, 32'h500);
    req[0] = 1'b0;
    tick();
    mem_done = 1'b1; mem_read_data = 32'h77;
    tick();
    check("busy_done", done, 3'b001);
    mem_done = 1'b0;
    tick();
    tick();
    check("withdrawn_no_gnt", gnt, 0);

    // Reset in the middle of WAIT, late mem_done ignored
    set_req(1, 32'h6000, 3'b101, 1'b1, 32'hCAFEF00D);
    req[1] = 1'b1;
    tick();
    check("mid_gnt", gnt, 3'b010);
    req[1] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_start", mem_start, 0);
    check("mid_rst_we", mem_write_enable, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_wdata", mem_write_data, 0);
    check("mid_rst_mode", mem_mode, 0);
    rst = 1'b0;
    tick();
    tick();
    mem_done = 1'b1; mem_read_data = 32'hBAD0_BAD0;
    tick();
    check("late_done_ignored", done, 0);
    check("late_rdata_ignored", rdata, 0);
    mem_done = 1'b0;
    tick();
    check("late_done_still_0", done, 0);

    // All three requesters held high from a fresh pointer
    set_req(0, 32'h10, 3'b010, 1'b0, 32'h0);
    set_req(1, 32'h20, 3'b010, 1'b0, 32'h0);
    set_req(2, 32'h30, 3'b010, 1'b0, 32'h0);
    req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("all_gnt%0d", k), gnt, exp_order[k]);
      tick();
      mem_done = 1'b1; mem_read_data = 32'(k + 32'h40);
      tick();
      check($sformatf("all_done%0d", k), done, exp_order[k]);
      check($sformatf("all_rdata%0d", k), rdata, 32'(k + 32'h40));
      mem_done = 1'b0;
      tick();
    end
    req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter that shares the CPU's single `memory_control` port among three requesters: instruction fetch (0), load/store (1) and debug/loader (2). It sits between the requesters and `memory_control`. Per transaction it picks one requester, latches its command, issues a one-cycle start pulse, waits for completion or timeout, and returns read data plus a done pulse to the granted requester.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT_CYCLES`, 64, maximum number of WAIT cycles before the arbiter aborts a transaction; 0 disables the timeout.
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `req`  in  3  request; bit i belongs to requester i.
- `req_addr`  in  3*ADDR_W  per-requester address; slice i is `[i*ADDR_W +: ADDR_W]`.
- `req_mode`  in  9  per-requester func3-style access mode, 3 bits each.
- `req_we`  in  3  per-requester write enable.
- `req_wdata`  in  3*DATA_W  per-requester write data.
- `gnt`  out  3  one-hot, one-cycle pulse: command accepted.
- `done`  out  3  one-hot, one-cycle pulse: transaction finished.
- `err`  out  3  one-hot, valid only together with `done`: transaction timed out.
- `rdata`  out  DATA_W  read data. Valid on the `done` cycle and held until the next `done`.
- `mem_start`  out  1  start pulse to `memory_control`.
- `mem_address`  out  ADDR_W  latched address.
- `mem_mode`  out  3  latched mode.
- `mem_write_enable`  out  1  latched write enable.
- `mem_write_data`  out  DATA_W  latched write data.
- `mem_active`  in  1  memory busy.
- `mem_done`  in  1  memory completion pulse.
- `mem_read_data`  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` bit is high and `mem_active` is 0, select a winner, latch its address/mode/we/wdata and its index, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive `mem_start`=1 and `gnt[idx]`=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: on `mem_done`, capture `mem_read_data` and go to RESP. If the counter reaches `TIMEOUT_CYCLES` first, capture 0, set the error flag and go to RESP. Otherwise increment the counter.
- RESP: `done[idx]`=1 for one cycle; `err[idx]`=error flag. Go to IDLE.
- Write transactions also capture `mem_read_data`; requesters ignore it.
- `mem_*` command outputs hold their latched values from ISSUE through RESP. They are not cleared in IDLE.
- A requester holds `req` and its fields stable until `gnt`, and drops `req` in the `gnt` cycle unless it wants another transaction.
- A `req` that drops before being granted is withdrawn; no transaction occurs.
- `mem_done` in IDLE, ISSUE or RESP is ignored.
- Timeout counter is a saturating $clog2(TIMEOUT_CYCLES+1)-bit counter.
- Reset (any state, including mid-WAIT):
  - next state IDLE;
  - `gnt`, `done`, `err`, `mem_start`, `mem_write_enable` = 0;
  - `rdata`, `mem_address`, `mem_write_data` = 0; `mem_mode` = 0;
  - round-robin pointer = 0.
- An in-flight memory operation is abandoned on reset. Its late `mem_done` is ignored and produces no `done` pulse.

## Timing
- Request in IDLE at cycle N, memory idle → `gnt` and `mem_start` at N+1.
- `mem_done` at cycle M → `done` and `rdata` at M+1.
- Minimum transaction time: 4 cycles plus memory latency.
- Next arbitration happens at the earliest in the cycle after `done`.
- No combinational path from any input to `mem_start`, `gnt` or `done`; all are registered state decodes.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN` defined:
  - round-robin selection;
  - pointer p (reset 0); search order p, p+1, p+2 (mod 3);
  - after a grant to i, p = (i+1) mod 3.
- Undefined: fixed priority 1 > 0 > 2 (load/store, then fetch, then debug); no pointer register.

## Structure
- Shared package (arch defines): state encodings, requester index constants (`REQ_FETCH`=0, `REQ_DATA`=1, `REQ_DEBUG`=2), mode width 3.
- One natural sub-module: `mem_arbiter_picker`. Combinational: `req` plus pointer in, one-hot winner and valid out. Holds both selection policies under the macro.

## Test plan
- Fetch alone: req[0], addr 0x100, mode 010; `mem_done` 3 cycles after `mem_start` with 0xDEADBEEF → gnt[0] at N+1; `mem_address`=0x100; done[0] with rdata 0xDEADBEEF one cycle after `mem_done`; err=0.
- Fixed priority (macro off): req[0] and req[1] rise together → gnt[1] first; req[0] is granted on the next IDLE cycle after done[1].
- Round robin (macro on): all three held high → grant order 0, 1, 2, 0, 1.
- Timeout: `TIMEOUT_CYCLES`=8, req[2], `mem_done` never arrives → done[2] and err[2] at 10 cycles after `mem_start`; rdata=0.
- Store: req[1], we=1, addr 0x2000, wdata 0x12345678 → `mem_write_enable`=1 and `mem_write_data`=0x12345678 during `mem_start`; done[1] with err=0.
- Reset mid-WAIT, then `mem_done` two cycles later → all outputs 0, no `done` pulse; FSM in IDLE.
